// File: rtl/dmem_access_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, RV32I
// load/store funct3 codes and default bus widths.
package dmem_access_arbiter_pkg;

    localparam int unsigned AW_DEF = 10;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } arb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_access_arbiter_arb_wait_counter.sv
// Saturating wait counter for a starved DBG request; clear has priority over
// increment, and tc_o flags the last busy cycle before a forced grant.
module arb_wait_counter
    import dmem_access_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares dmem between the MEM-stage load/store port and a debug/loader port;
// DBG uses idle slots, or forces a one-cycle pipeline stall after MAX_WAIT busy cycles.
module dmem_access_arbiter
    import dmem_access_arbiter_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [2:0]    funct3M,
    input  logic [AW-1:0] AddrM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    input  logic          dbg_valid,
    input  logic          dbg_we,
    input  logic [2:0]    dbg_funct3,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ready,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          StallMem,
    output logic          mem_re,
    output logic          mem_we,
    output logic [2:0]    mem_funct3,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic          cpu_act;
    logic          dbg_grant;
    logic          dbg_sel;
    logic          wait_inc;
    logic          wait_clr;
    logic          wait_tc;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    assign cpu_act = MemReadM | MemWriteM;

    // Count only while DBG is blocked by the CPU in S_CPU; any other cycle,
    // or the forced-grant transition itself, restarts the count.
    assign wait_inc = (state_q == S_CPU) && dbg_valid && cpu_act;
    assign wait_clr = !wait_inc || wait_tc;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (wait_clr),
        .inc_i (wait_inc),
        .tc_o  (wait_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_CPU;
        unique case (state_q)
            S_CPU: begin
                if (wait_inc && wait_tc) begin
                    state_d = S_DBG;
                end
            end
            S_DBG:   state_d = S_CPU;
            default: state_d = S_CPU;
        endcase
    end

    always_comb begin
        dbg_grant = 1'b0;
        dbg_sel   = 1'b0;
        unique case (state_q)
            S_CPU: begin
                dbg_grant = dbg_valid && !cpu_act;
                dbg_sel   = dbg_grant;
            end
            S_DBG: begin
                // CPU enables stay masked here even if DBG dropped its request.
                dbg_grant = dbg_valid;
                dbg_sel   = 1'b1;
            end
            default: ;
        endcase

        StallMem  = (state_q == S_DBG);
        dbg_ready = dbg_grant;

        if (dbg_sel) begin
            mem_re     = dbg_grant && !dbg_we;
            mem_we     = dbg_grant && dbg_we;
            mem_funct3 = dbg_funct3;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
        end else begin
            mem_re     = MemReadM;
            mem_we     = MemWriteM;
            mem_funct3 = funct3M;
            mem_addr   = AddrM;
            mem_wdata  = WriteDataM;
        end
    end

    assign ReadDataM = mem_rdata;

    always_comb begin
        rvalid_d = dbg_grant && !dbg_we;
        rdata_d  = rvalid_d ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter: directed CPU/DBG traffic against a
// word-wide behavioural dmem; DBG load responses are checked by a monitor.
module tb_dmem_access_arbiter;
    import dmem_access_arbiter_pkg::*;

    localparam int unsigned AW       = 10;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemReadM, MemWriteM;
    logic [2:0]    funct3M;
    logic [AW-1:0] AddrM;
    logic [DW-1:0] WriteDataM, ReadDataM;
    logic          dbg_valid, dbg_we;
    logic [2:0]    dbg_funct3;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ready, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          StallMem, mem_re, mem_we;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_access_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .dbg_valid  (dbg_valid),
        .dbg_we     (dbg_we),
        .dbg_funct3 (dbg_funct3),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ready  (dbg_ready),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .StallMem   (StallMem),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word-wide dmem: combinational read, write on posedge.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          stall_log[$];
    int          stall_run = 0;
    logic [31:0] exp_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every DBG load response, plus protocol checks.
    always @(negedge clk) begin
        if (reset) begin
            if (dbg_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got data 0x%08h expected no response", dbg_rdata);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("dbg_rdata", dbg_rdata, exp_word);
                end
            end
            chk("a_no_cpu_we_in_stall", 32'(StallMem && mem_we && !(dbg_ready && dbg_we)), 32'd0);
            chk("a_ready_implies_valid", 32'(dbg_ready && !dbg_valid), 32'd0);
            if (StallMem) begin
                stall_run++;
                stall_log.push_back(cyc);
            end else begin
                stall_run = 0;
            end
            chk("a_stall_max_one_cycle", 32'(stall_run > 1), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one DBG request and hold it until accepted; checks wait length and grant mux.
    task automatic dbg_req(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input int exp_wait, input logic exp_stall, input logic [31:0] exp_rdata,
                           input string tag);
        int waited = 0;
        bit got    = 1'b0;
        dbg_valid  = 1'b1;
        dbg_we     = we;
        dbg_funct3 = we ? F3_SW : F3_LW;
        dbg_addr   = addr;
        dbg_wdata  = wdata;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dbg_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: dbg_ready not seen, expected within 20 cycles", tag);
        end else begin
            chk({tag, "_wait"}, 32'(waited), 32'(exp_wait));
            chk({tag, "_stall"}, 32'(StallMem), 32'(exp_stall));
            chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
            chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
            chk({tag, "_mem_re"}, 32'(mem_re), 32'(!we));
            if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
            else exp_q.push_back(exp_rdata);
        end
        step();
        dbg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hA5A5_0010;
        mem[8'h0C] = 32'h0BAD_0030;
        mem[8'h10] = 32'h1111_0040;
        mem[8'h11] = 32'h2222_0044;

        reset = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = F3_LW; AddrM = '0; WriteDataM = '0;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_funct3 = F3_LW; dbg_addr = '0; dbg_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(StallMem), 32'd0);
        chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_ready", 32'(dbg_ready), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Idle-slot DBG load.
        dbg_req(1'b0, 10'h010, 32'h0, 0, 1'b0, 32'hA5A5_0010, "t1");
        @(negedge clk);
        chk("t1_rvalid_next", 32'(dbg_rvalid), 32'd1);
        step();

        // Forced grant under continuous CPU stores to the same word.
        MemWriteM = 1'b1; funct3M = F3_SW; AddrM = 10'h020; WriteDataM = 32'hDEAD_BEEF;
        dbg_req(1'b0, 10'h020, 32'h0, 4, 1'b1, 32'hDEAD_BEEF, "t2");
        @(negedge clk);
        chk("t2_stall_released", 32'(StallMem), 32'd0);
        chk("t2_cpu_we_back", 32'(mem_we), 32'd1);
        step();
        MemWriteM = 1'b0;

        // DBG store forced in during CPU loads of the same word.
        MemReadM = 1'b1; funct3M = F3_LW; AddrM = 10'h030;
        fork
            dbg_req(1'b1, 10'h030, 32'h1234_5678, 4, 1'b1, 32'h0, "t3");
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("t3_cpu_old", ReadDataM, 32'h0BAD_0030);
                end
            end
        join
        @(negedge clk);
        chk("t3_cpu_new", ReadDataM, 32'h1234_5678);
        step();

        // Counter boundary: CPU frees the bus on the last waiting cycle.
        AddrM = 10'h020;
        fork
            dbg_req(1'b0, 10'h040, 32'h0, 3, 1'b0, 32'h1111_0040, "t6");
            begin
                repeat (3) @(negedge clk);
                step();
                MemReadM = 1'b0;
            end
        join
        step();

        // Idle-slot DBG store, read back through DBG.
        dbg_req(1'b1, 10'h050, 32'hCAFE_F00D, 0, 1'b0, 32'h0, "t7w");
        dbg_req(1'b0, 10'h050, 32'h0, 0, 1'b0, 32'hCAFE_F00D, "t7r");
        step();

        // Reset dropped while in S_DBG.
        MemReadM = 1'b1; AddrM = 10'h020;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_funct3 = F3_LW; dbg_addr = 10'h010;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (StallMem) break;
        end
        chk("t4_in_sdbg", 32'(StallMem), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("t4_rst_stall", 32'(StallMem), 32'd0);
        chk("t4_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("t4_rst_ready", 32'(dbg_ready), 32'd0);
        step();
        dbg_valid = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_post_stall", 32'(StallMem), 32'd0);
            chk("t4_post_load", ReadDataM, 32'hDEAD_BEEF);
        end
        step();

        // Back-to-back forced grants under continuous CPU loads.
        stall_log.delete();
        dbg_req(1'b0, 10'h040, 32'h0, 4, 1'b1, 32'h1111_0040, "t5a");
        dbg_req(1'b0, 10'h044, 32'h0, 4, 1'b1, 32'h2222_0044, "t5b");
        MemReadM = 1'b0;
        repeat (3) step();
        chk("t5_stall_count", 32'(stall_log.size()), 32'd2);
        if (stall_log.size() == 2) chk("t5_stall_spacing", 32'(stall_log[1] - stall_log[0]), 32'd5);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
